// File: rtl/bcd_converter.sv
// bcd_converter: sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// A value is accepted in IDLE, converted over WIDTH cycles in CONVERT, and the
// packed BCD result is registered with a one-cycle out_valid pulse.
// Optional feature macro: BCD_RANGE_CHECK_EN -- when defined, inputs that do not
// fit in DIGITS decimal digits saturate to all 9s and raise err; otherwise the
// result wraps (value mod 10**DIGITS) and err is tied low.
module bcd_converter #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcdout,
  output logic                  err
);

  // Number of decimal digits needed to represent 2**w-1.
  function automatic int calc_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (v > 0) begin
        v = v / 10;
        n++;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  localparam int NEED_DIGITS = calc_digits(WIDTH);
  // Accumulator holds the full-range result and is never narrower than the output.
  localparam int ACC_DIGITS  = (NEED_DIGITS > DIGITS) ? NEED_DIGITS : DIGITS;
  localparam int ACC_W       = 4 * ACC_DIGITS;
  localparam int CW          = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                vld_q, vld_d;

  logic [ACC_W-1:0]    corr;
  logic [ACC_W-1:0]    acc_shift;

  // Add 3 to every accumulator nibble that is 5 or more before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_DIGITS; gi++) begin : g_adj
      assign corr[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? (acc_q[4*gi +: 4] + 4'd3)
                                                           : acc_q[4*gi +: 4];
    end
  endgenerate

  // Shift {accumulator, binary} left by one; the top accumulator bit falls off.
  assign acc_shift = ACC_W'({corr, bin_q[WIDTH-1]});

`ifdef BCD_RANGE_CHECK_EN
  logic err_q, err_d;
  logic upper_nz;

  // Any non-zero digit above the output digits means the value is out of range.
  generate
    if (ACC_DIGITS > DIGITS) begin : g_ovf
      assign upper_nz = |acc_shift[ACC_W-1:4*DIGITS];
    end else begin : g_no_ovf
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign err = err_q;

  // Error flag register, updated only with a completed conversion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign err = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state logic: accept in IDLE, one shift-add-3 iteration per CONVERT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    vld_d   = 1'b0;
`ifdef BCD_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = binin;
          cnt_d   = CW'(WIDTH);
          acc_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        acc_d = acc_shift;
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          bcd_d   = acc_shift[4*DIGITS-1:0];
`ifdef BCD_RANGE_CHECK_EN
          if (upper_nz) bcd_d = {DIGITS{4'h9}};
          err_d = upper_nz;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign bcdout    = bcd_q;

endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: directed self-checking bench for bcd_converter (DIGITS=4, WIDTH=14).
module tb_bcd_converter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] binin;
  logic        out_valid;
  logic [15:0] bcdout;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_converter #(.DIGITS(4), .WIDTH(14)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binin     (binin),
    .out_valid (out_valid),
    .bcdout    (bcdout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the out_valid pulse; lat = negedges counted, -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called at a negedge with the converter idle; returns at the out_valid negedge.
  task automatic run_conv(input logic [13:0] v, output int lat);
    binin    = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
  endtask

  int lat;
  int pulses;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    binin    = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bcdout", {16'd0, bcdout}, 32'h0000);
    chk("rst_err", {31'd0, err}, 32'd0);

    // 1234, accepted on the very first edge after reset release
    reset = 1'b1;
    run_conv(14'd1234, lat);
    chk("lat_1234", lat, 14);
    chk("bcd_1234", {16'd0, bcdout}, 32'h1234);
    chk("err_1234", {31'd0, err}, 32'd0);
    $display("txn 1234 -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);
    @(negedge clk);
    chk("pulse_one_cycle", {31'd0, out_valid}, 32'd0);
    chk("hold_1234", {16'd0, bcdout}, 32'h1234);

    // 0 then 9999 back-to-back, second accept in the out_valid cycle
    binin    = 14'd0;
    in_valid = 1'b1;
    @(negedge clk);
    binin = 14'd9999;
    wait_out(lat);
    chk("lat_0", lat, 14);
    chk("bcd_0", {16'd0, bcdout}, 32'h0000);
    chk("err_0", {31'd0, err}, 32'd0);
    $display("txn 0 -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);
    wait_out(lat);
    in_valid = 1'b0;
    chk("b2b_spacing", lat, 15);
    chk("bcd_9999", {16'd0, bcdout}, 32'h9999);
    chk("err_9999", {31'd0, err}, 32'd0);
    $display("txn 9999 -> bcd=%h err=%0d spacing=%0d", bcdout, err, lat);

    // Out-of-range values
    run_conv(14'd12345, lat);
    chk("lat_12345", lat, 14);
`ifdef BCD_RANGE_CHECK_EN
    chk("bcd_12345", {16'd0, bcdout}, 32'h9999);
    chk("err_12345", {31'd0, err}, 32'd1);
`else
    chk("bcd_12345", {16'd0, bcdout}, 32'h2345);
    chk("err_12345", {31'd0, err}, 32'd0);
`endif
    $display("txn 12345 -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);
    run_conv(14'd16383, lat);
`ifdef BCD_RANGE_CHECK_EN
    chk("bcd_16383", {16'd0, bcdout}, 32'h9999);
    chk("err_16383", {31'd0, err}, 32'd1);
`else
    chk("bcd_16383", {16'd0, bcdout}, 32'h6383);
    chk("err_16383", {31'd0, err}, 32'd0);
`endif
    $display("txn 16383 -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);
    run_conv(14'd10000, lat);
`ifdef BCD_RANGE_CHECK_EN
    chk("bcd_10000", {16'd0, bcdout}, 32'h9999);
    chk("err_10000", {31'd0, err}, 32'd1);
`else
    chk("bcd_10000", {16'd0, bcdout}, 32'h0000);
    chk("err_10000", {31'd0, err}, 32'd0);
`endif
    $display("txn 10000 -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);

    // 4321 with binin changed and in_valid held during CONVERT
    binin    = 14'd4321;
    in_valid = 1'b1;
    @(negedge clk);
    binin = 14'd1111;
    chk("busy_4321_k0", {31'd0, in_ready}, 32'd0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      chk("busy_4321", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("lat_4321", lat, 14);
    chk("bcd_4321", {16'd0, bcdout}, 32'h4321);
    $display("txn 4321 (binin->1111 mid-convert) -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("no_queued_value", pulses, 0);
    chk("hold_4321", {16'd0, bcdout}, 32'h4321);

    // 5678 aborted by reset at iteration 7
    binin    = 14'd5678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_bcdout", {16'd0, bcdout}, 32'h0000);
    chk("abort_err", {31'd0, err}, 32'd0);
    $display("txn 5678 aborted by reset -> bcd=%h in_ready=%0d", bcdout, in_ready);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("no_out_after_abort", pulses, 0);

    run_conv(14'd42, lat);
    chk("lat_42", lat, 14);
    chk("bcd_42", {16'd0, bcdout}, 32'h0042);
    chk("err_42", {31'd0, err}, 32'd0);
    $display("txn 42 -> bcd=%h err=%0d lat=%0d", bcdout, err, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
